// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder
// Data-memory responder on the far side of the cardinal_processor Dmem port.
// It services core loads and stores with a one-cycle registered read. A host
// port gets the array only when the core is idle. After reset, the array is
// zeroed one word per cycle before any access is accepted.
//
// Ports (big-endian bit numbering, as in the core):
//   Clock       rising-edge clock
//   Reset       asynchronous, active-high
//   Mem_Addr    core word address
//   Data_In     core store data
//   DmemEn      core access request (load or store)
//   DmemWrEn    core store when high (qualified by DmemEn)
//   Data_Out    registered load data to the core
//   Host_En     host access request
//   Host_WrEn   host write when high
//   Host_Addr   host word address
//   Host_Wdata  host write data
//   Host_Rdata  registered host read data
//   Host_Grant  host request accepted this cycle (combinational)
//   Init_Done   high once the clear has finished (RUN state)
//
// state    | meaning
// ST_CLEAR | writing zero to mem[clr_cnt], all requests ignored
// ST_RUN   | core accesses first, host accesses when the core is idle
module dmem_responder #(
  parameter int unsigned DEPTH          = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [0:7]  Mem_Addr,
  input  logic [0:63] Data_In,
  input  logic        DmemEn,
  input  logic        DmemWrEn,
  output logic [0:63] Data_Out,
  input  logic        Host_En,
  input  logic        Host_WrEn,
  input  logic [0:7]  Host_Addr,
  input  logic [0:63] Host_Wdata,
  output logic [0:63] Host_Rdata,
  output logic        Host_Grant,
  output logic        Init_Done
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [8:0] DEPTH_LIM   = 9'(DEPTH);
  localparam logic [7:0] CLR_LAST    = 8'(DEPTH - 1);
  localparam state_t     RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t      state_q, state_d;
  logic [7:0]  clr_cnt_q, clr_cnt_d;

  // Full 8-bit address space is declared; entries at or above DEPTH are never
  // written or read because every access is range-gated below.
  logic [0:63] mem [0:255];

  logic        mem_we;
  logic [0:7]  mem_waddr;
  logic [0:63] mem_wdata;
  logic        core_rd, host_rd;
  logic        core_in_range, host_in_range;

  assign core_in_range = {1'b0, Mem_Addr}  < DEPTH_LIM;
  assign host_in_range = {1'b0, Host_Addr} < DEPTH_LIM;
  assign Init_Done     = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_cnt_q;
    mem_wdata  = '0;
    core_rd    = 1'b0;
    host_rd    = 1'b0;
    Host_Grant = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      ST_RUN: begin
        Host_Grant = Host_En & ~DmemEn;
        if (DmemEn) begin
          if (DmemWrEn) begin
            mem_we    = core_in_range;
            mem_waddr = Mem_Addr;
            mem_wdata = Data_In;
          end else begin
            core_rd = 1'b1;
          end
        end else if (Host_Grant) begin
          if (Host_WrEn) begin
            mem_we    = host_in_range;
            mem_waddr = Host_Addr;
            mem_wdata = Host_Wdata;
          end else begin
            host_rd = 1'b1;
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // Reset gates the write so nothing lands on the edge where reset rises.
  always_ff @(posedge Clock) begin
    if (mem_we && !Reset) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= '0;
      Data_Out   <= '0;
      Host_Rdata <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      if (core_rd) Data_Out   <= core_in_range ? mem[Mem_Addr]  : '0;
      if (host_rd) Host_Rdata <= host_in_range ? mem[Host_Addr] : '0;
    end
  end

endmodule
